lm_sm_sequencer: RTL and testbench

Initiator side of the 64×16 data memory port: a multicycle sequencer that executes Load-Multiple / Store-Multiple transfers between the 8-entry register file and consecutive memory words. It drives the memory's active-low write/read strobes, address and write data from posedge registers, so every access is sampled by the memory on the following negedge. Load data is returned to the register file through a registered write port. It sits between the control FSM (start/busy/done) and the memory / register-file ports.

---
 rtl/lm_sm_sequencer.sv | 149 ++++++++++++++
 tb/tb_lm_sm_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// Load-Multiple / Store-Multiple sequencer: walks a register mask from the
// lowest set bit upward, issuing one memory access per cycle at consecutive
// (wrapping) word addresses. Loads return to the register file one cycle later.
module lm_sm_sequencer #(
   parameter int unsigned ADDR_W = 6,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned NREG   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_store,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [NREG-1:0]   reg_mask,
   output logic [2:0]        rf_raddr,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_in,
   output logic              mem_write_n,
   output logic              mem_read_n,
   input  logic [DATA_W-1:0] mem_out,
   output logic              rf_we,
   output logic [2:0]        rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

   state_e            state_q, state_d;
   logic [NREG-1:0]   mask_q, mask_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              store_q, store_d;
   logic [2:0]        tag_q, tag_d;
   logic              tag_valid_q, tag_valid_d;

   logic [ADDR_W-1:0] mem_addr_d;
   logic [DATA_W-1:0] mem_in_d;
   logic              mem_write_n_d, mem_read_n_d;
   logic              rf_we_d;
   logic [2:0]        rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_d;
   logic              busy_d, done_d;

   logic [2:0]        low_idx;

   // Lowest set bit of the remaining mask; scanning downward lets the lowest win.
   always_comb begin
      low_idx = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (mask_q[i]) low_idx = 3'(i);
      end
   end

   assign rf_raddr = low_idx;

   // Next-state and registered-output decode.
   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      ptr_d         = ptr_q;
      store_d       = store_q;
      tag_d         = tag_q;
      tag_valid_d   = 1'b0;
      mem_addr_d    = mem_addr;
      mem_in_d      = mem_in;
      mem_write_n_d = 1'b1;
      mem_read_n_d  = 1'b1;
      busy_d        = busy;
      done_d        = 1'b0;
      // Load capture: data for the read issued last cycle is on mem_out now.
      rf_we_d       = tag_valid_q;
      rf_waddr_d    = tag_valid_q ? tag_q : rf_waddr;
      rf_wdata_d    = tag_valid_q ? mem_out : rf_wdata;

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            // busy is already low here, so a start held through done is taken.
            if (start) begin
               mask_d  = reg_mask;
               ptr_d   = base_addr;
               store_d = is_store;
               busy_d  = 1'b1;
               state_d = StXfer;
            end
         end
         StXfer: begin
            if (mask_q != '0) begin
               mem_addr_d = ptr_q;
               if (store_q) begin
                  mem_in_d      = rf_rdata;
                  mem_write_n_d = 1'b0;
               end else begin
                  mem_read_n_d = 1'b0;
                  tag_d        = low_idx;
                  tag_valid_d  = 1'b1;
               end
               mask_d = mask_q & ~(NREG'(1) << low_idx);
               ptr_d  = ptr_q + ADDR_W'(1);
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset aborts any transfer in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         mask_q      <= '0;
         ptr_q       <= '0;
         store_q     <= 1'b0;
         tag_q       <= '0;
         tag_valid_q <= 1'b0;
         mem_addr    <= '0;
         mem_in      <= '0;
         mem_write_n <= 1'b1;
         mem_read_n  <= 1'b1;
         rf_we       <= 1'b0;
         rf_waddr    <= '0;
         rf_wdata    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         ptr_q       <= ptr_d;
         store_q     <= store_d;
         tag_q       <= tag_d;
         tag_valid_q <= tag_valid_d;
         mem_addr    <= mem_addr_d;
         mem_in      <= mem_in_d;
         mem_write_n <= mem_write_n_d;
         mem_read_n  <= mem_read_n_d;
         rf_we       <= rf_we_d;
         rf_waddr    <= rf_waddr_d;
         rf_wdata    <= rf_wdata_d;
         busy        <= busy_d;
         done        <= done_d;
      end
   end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer with a 64x16 memory and 8-entry register
// file model. Outputs are sampled 1 time unit after each posedge.
module tb_lm_sm_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [5:0]  base_addr;
   logic [7:0]  reg_mask;
   logic [2:0]  rf_raddr;
   logic [15:0] rf_rdata;
   logic [5:0]  mem_addr;
   logic [15:0] mem_in;
   logic        mem_write_n;
   logic        mem_read_n;
   logic [15:0] mem_out;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        busy;
   logic        done;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] mem [64];
   logic [15:0] rf [8];

   // Bench-side preload port into the memory / register-file models.
   logic        pk_mem = 1'b0;
   logic        pk_rf  = 1'b0;
   logic [5:0]  pk_addr = '0;
   logic [15:0] pk_data = '0;

   localparam logic [15:0] INIT_RF [8] = '{16'h1111, 16'h0101, 16'h2222, 16'h0303,
                                           16'h0404, 16'h5555, 16'h0606, 16'h7777};

   lm_sm_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .is_store    (is_store),
      .base_addr   (base_addr),
      .reg_mask    (reg_mask),
      .rf_raddr    (rf_raddr),
      .rf_rdata    (rf_rdata),
      .mem_addr    (mem_addr),
      .mem_in      (mem_in),
      .mem_write_n (mem_write_n),
      .mem_read_n  (mem_read_n),
      .mem_out     (mem_out),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Memory samples strobes on the negedge inside the access cycle.
   always @(negedge clk) begin
      if (!mem_write_n) mem[mem_addr] <= mem_in;
      else if (pk_mem) mem[pk_addr] <= pk_data;
      if (!mem_read_n) mem_out <= mem[mem_addr];
   end

   // Register file commits on posedge; combinational read.
   always @(posedge clk) begin
      if (rf_we) rf[rf_waddr] <= rf_wdata;
      else if (pk_rf) rf[pk_addr[2:0]] <= pk_data;
   end

   assign rf_rdata = rf[rf_raddr];

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input bit to_rf, input logic [5:0] a, input logic [15:0] d);
      pk_rf   = to_rf;
      pk_mem  = !to_rf;
      pk_addr = a;
      pk_data = d;
      tick();
      pk_rf  = 1'b0;
      pk_mem = 1'b0;
   endtask

   // Checks one transfer starting right after its start edge S.
   task automatic xfer_body(input logic st, input logic [5:0] base, input logic [7:0] mask,
                            input bit poke, input bit hold, input logic nst,
                            input logic [5:0] nbase, input logic [7:0] nmask);
      int         n;
      logic [2:0] idx [8];
      logic [5:0] a;
      bit         last_ld;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         if (mask[i]) begin
            idx[n] = 3'(i);
            n++;
         end
      end
      check_eq("busy_at_start", 16'(busy), 16'd1);
      check_eq("done_at_start", 16'(done), 16'd0);
      for (int k = 0; k < n; k++) begin
         if (poke && k == 2) begin
            start    = 1'b1;
            is_store = ~st;
            reg_mask = 8'h01;
         end
         tick();
         start = 1'b0;
         a = base + 6'(k);
         check_eq("mem_addr", 16'(mem_addr), 16'(a));
         check_eq("write_n", 16'(mem_write_n), 16'(!st));
         check_eq("read_n", 16'(mem_read_n), 16'(st));
         check_eq("busy_xfer", 16'(busy), 16'd1);
         check_eq("done_xfer", 16'(done), 16'd0);
         if (st) check_eq("mem_in", mem_in, rf[idx[k]]);
         if (!st && k > 0) begin
            check_eq("rf_we_ld", 16'(rf_we), 16'd1);
            check_eq("rf_waddr", 16'(rf_waddr), 16'(idx[k-1]));
            check_eq("rf_wdata", rf_wdata, mem[a - 6'd1]);
         end else begin
            check_eq("rf_we_idle", 16'(rf_we), 16'd0);
         end
      end
      tick();
      last_ld = !st && n > 0;
      check_eq("write_n_end", 16'(mem_write_n), 16'd1);
      check_eq("read_n_end", 16'(mem_read_n), 16'd1);
      check_eq("busy_end", 16'(busy), 16'd0);
      check_eq("done_pulse", 16'(done), 16'd1);
      check_eq("rf_we_end", 16'(rf_we), 16'(last_ld));
      if (last_ld) begin
         check_eq("rf_waddr_end", 16'(rf_waddr), 16'(idx[n-1]));
         check_eq("rf_wdata_end", rf_wdata, mem[base + 6'(n - 1)]);
      end
      if (hold) begin
         start     = 1'b1;
         is_store  = nst;
         base_addr = nbase;
         reg_mask  = nmask;
      end
      tick();
      start = 1'b0;
      check_eq("done_low", 16'(done), 16'd0);
      check_eq("rf_we_after", 16'(rf_we), 16'd0);
      check_eq("busy_after", 16'(busy), 16'(hold));
   endtask

   task automatic run_xfer(input logic st, input logic [5:0] base, input logic [7:0] mask);
      start     = 1'b1;
      is_store  = st;
      base_addr = base;
      reg_mask  = mask;
      tick();
      start = 1'b0;
      xfer_body(st, base, mask, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      is_store  = 1'b0;
      base_addr = '0;
      reg_mask  = '0;
      repeat (2) tick();
      check_eq("rst_write_n", 16'(mem_write_n), 16'd1);
      check_eq("rst_read_n", 16'(mem_read_n), 16'd1);
      check_eq("rst_busy", 16'(busy), 16'd0);
      check_eq("rst_done", 16'(done), 16'd0);
      check_eq("rst_rf_we", 16'(rf_we), 16'd0);
      check_eq("rst_mem_addr", 16'(mem_addr), 16'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) preload(1'b1, 6'(i), INIT_RF[i]);

      // Store-multiple, mask 1010_0101 from address 10.
      run_xfer(1'b1, 6'd10, 8'hA5);
      check_eq("sm_mem10", mem[10], 16'h1111);
      check_eq("sm_mem11", mem[11], 16'h2222);
      check_eq("sm_mem12", mem[12], 16'h5555);
      check_eq("sm_mem13", mem[13], 16'h7777);

      // Load-multiple across the 63->0 wrap.
      preload(1'b0, 6'd62, 16'hA0A0);
      preload(1'b0, 6'd63, 16'hB1B1);
      preload(1'b0, 6'd0, 16'hC7C7);
      run_xfer(1'b0, 6'd62, 8'h83);
      check_eq("lm_r0", rf[0], 16'hA0A0);
      check_eq("lm_r1", rf[1], 16'hB1B1);
      check_eq("lm_r7", rf[7], 16'hC7C7);
      check_eq("lm_r2_kept", rf[2], 16'h2222);

      // Empty masks in both directions.
      run_xfer(1'b1, 6'd3, 8'h00);
      run_xfer(1'b0, 6'd3, 8'h00);

      // Full SM from 60 with a stray start mid-transfer, then start held
      // through the done cycle launching a second SM.
      start     = 1'b1;
      is_store  = 1'b1;
      base_addr = 6'd60;
      reg_mask  = 8'hFF;
      tick();
      start = 1'b0;
      xfer_body(1'b1, 6'd60, 8'hFF, 1'b1, 1'b1, 1'b1, 6'd40, 8'h03);
      xfer_body(1'b1, 6'd40, 8'h03, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0);
      check_eq("full_mem60", mem[60], 16'hA0A0);
      check_eq("full_mem63", mem[63], 16'h0303);
      check_eq("full_mem0", mem[0], 16'h0404);
      check_eq("full_mem3", mem[3], 16'hC7C7);
      check_eq("second_mem40", mem[40], 16'hA0A0);
      check_eq("second_mem41", mem[41], 16'hB1B1);

      // Reset after two issued LM reads of mask 0x0F.
      start     = 1'b1;
      is_store  = 1'b0;
      base_addr = 6'd20;
      reg_mask  = 8'h0F;
      tick();
      start = 1'b0;
      tick();
      tick();
      check_eq("pre_rst_rf_we", 16'(rf_we), 16'd1);
      reset = 1'b1;
      #1;
      check_eq("abort_read_n", 16'(mem_read_n), 16'd1);
      check_eq("abort_write_n", 16'(mem_write_n), 16'd1);
      check_eq("abort_rf_we", 16'(rf_we), 16'd0);
      check_eq("abort_rf_waddr", 16'(rf_waddr), 16'd0);
      check_eq("abort_rf_wdata", rf_wdata, 16'd0);
      check_eq("abort_mem_addr", 16'(mem_addr), 16'd0);
      check_eq("abort_mem_in", mem_in, 16'd0);
      check_eq("abort_busy", 16'(busy), 16'd0);
      check_eq("abort_done", 16'(done), 16'd0);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_eq("post_rst_rf_we", 16'(rf_we), 16'd0);
         check_eq("post_rst_read_n", 16'(mem_read_n), 16'd1);
      end
      check_eq("post_rst_r0", rf[0], 16'hA0A0);

      preload(1'b0, 6'd5, 16'h5A5A);
      run_xfer(1'b0, 6'd5, 8'h01);
      check_eq("recover_r0", rf[0], 16'h5A5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
